alu_seq: RTL and testbench

// Parametrised, handshaked successor to the single-cycle execute ALU. Accepts one

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mul_iter.sv | 77 +++++++
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, FSM state encodings and operand
//               typedefs for the handshaked sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode width used by the default configuration of alu_seq
    localparam int ALU_OP_W = 4;

    typedef logic [ALU_OP_W-1:0] op_t;

    // Opcode encodings; anything not listed here executes as SUB
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_AND = 3;
    localparam int OP_OR  = 4;
    localparam int OP_XOR = 5;
    localparam int OP_SLT = 6;
    localparam int OP_SLL = 7;
    localparam int OP_SRL = 8;

    // Handshake FSM states
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_MUL_BUSY = 1'b1;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative shift-add unsigned multiplier. Retires MUL_BPC
//               multiplier bits per cycle; o_done pulses combinationally on
//               the final iteration with the full 2*WIDTH product on
//               o_product, so the consumer can capture it on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int ITER  = WIDTH / MUL_BPC;
    localparam int CNT_W = $clog2(ITER + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    logic [2*WIDTH-1:0] w_partial;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;

    // Partial product for the MUL_BPC low multiplier bits of this iteration
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    assign w_acc_next = r_acc + w_partial;
    assign w_last     = (r_cnt == CNT_W'(ITER - 1));
    assign o_done     = r_busy & w_last;
    assign o_product  = w_acc_next;

    // Operand latch on start, then one shift-add step per cycle while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << MUL_BPC;
            r_mplier <= r_mplier >> MUL_BPC;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule : alu_mul_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU. Single-cycle datapath for all ops except MUL,
//               which runs on alu_mul_iter. Result and flags sit in an output
//               register that is held while the consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int OP_W    = 4,
    parameter int MUL_BPC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    control,
    input  logic [WIDTH-1:0]   oper1,
    input  logic [WIDTH-1:0]   oper2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               negative,
    output logic               carry,
    output logic               overflow,
    output logic               busy
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    logic [0:0]         r_state;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_negative;
    logic               r_carry;
    logic               r_overflow;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_sub;
    logic [SH_W-1:0]    w_shamt;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_load_res;
    logic               w_load_carry;
    logic               w_load_ovf;

    assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (control == OP_W'(OP_MUL));
    assign w_mul_start = w_accept && w_is_mul;

    assign w_add   = {1'b0, oper1} + {1'b0, oper2};
    assign w_sub   = oper1 - oper2;
    assign w_shamt = oper2[SH_W-1:0];

    alu_mul_iter #(
        .WIDTH   (WIDTH),
        .MUL_BPC (MUL_BPC)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (oper1),
        .i_b       (oper2),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // Single-cycle datapath; unlisted opcodes fall through to SUB
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (control)
            OP_W'(OP_ADD): begin
                w_res   = w_add[WIDTH-1:0];
                w_carry = w_add[WIDTH];
                w_ovf   = (oper1[MSB] == oper2[MSB]) && (w_add[MSB] != oper1[MSB]);
            end
            OP_W'(OP_MUL): w_res = '0;
            OP_W'(OP_AND): w_res = oper1 & oper2;
            OP_W'(OP_OR):  w_res = oper1 | oper2;
            OP_W'(OP_XOR): w_res = oper1 ^ oper2;
            OP_W'(OP_SLT): w_res = {{(WIDTH-1){1'b0}}, ($signed(oper1) < $signed(oper2))};
            OP_W'(OP_SLL): w_res = oper1 << w_shamt;
            OP_W'(OP_SRL): w_res = oper1 >> w_shamt;
            default: begin
                w_res   = w_sub;
                w_carry = (oper1 < oper2);
                w_ovf   = (oper1[MSB] != oper2[MSB]) && (w_sub[MSB] != oper1[MSB]);
            end
        endcase
    end

    // Value to be loaded into the output register this edge, from either source
    always_comb begin
        w_load_res   = w_res;
        w_load_carry = w_carry;
        w_load_ovf   = w_ovf;
        if (w_mul_done) begin
            w_load_res   = w_mul_prod[WIDTH-1:0];
            w_load_carry = 1'b0;
            w_load_ovf   = |w_mul_prod[2*WIDTH-1:WIDTH];
        end
    end

    // Handshake FSM and output register; flags come from the value being loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state     <= ST_MUL_BUSY;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_result    <= w_load_res;
                            r_zero      <= ~|w_load_res;
                            r_negative  <= w_load_res[MSB];
                            r_carry     <= w_load_carry;
                            r_overflow  <= w_load_ovf;
                        end
                    end else if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    if (w_mul_done) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_load_res;
                        r_zero      <= ~|w_load_res;
                        r_negative  <= w_load_res[MSB];
                        r_carry     <= w_load_carry;
                        r_overflow  <= w_load_ovf;
                    end
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign busy      = (r_state == ST_MUL_BUSY);

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq. A reference model predicts
//               each accepted request into a scoreboard queue; a monitor pops
//               and compares on every output handoff. Scenario tasks add
//               latency, stability and handshake checks inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  control = 4'd0;
    logic [31:0] oper1 = '0;
    logic [31:0] oper2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, negative, carry, overflow, busy;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    exp_t scb[$];
    int   tests_run = 0;
    int   fails     = 0;
    bit   rand_done = 1'b0;

    alu_seq #(.WIDTH(32), .OP_W(4), .MUL_BPC(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .oper1     (oper1),
        .oper2     (oper2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model computed from first principles (64-bit arithmetic)
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, s;
        logic [63:0] p;
        logic [32:0] u;
        e   = '0;
        sa  = $signed({{32{a[31]}}, a});
        sbv = $signed({{32{b[31]}}, b});
        case (op)
            4'd0: begin
                u     = {1'b0, a} + {1'b0, b};
                e.res = u[31:0];
                e.c   = u[32];
                s     = sa + sbv;
                e.v   = (s > MAXS) || (s < MINS);
            end
            4'd2: begin
                p     = {32'b0, a} * {32'b0, b};
                e.res = p[31:0];
                e.v   = (p[63:32] != 32'd0);
            end
            4'd3: e.res = a & b;
            4'd4: e.res = a | b;
            4'd5: e.res = a ^ b;
            4'd6: e.res = (sa < sbv) ? 32'd1 : 32'd0;
            4'd7: e.res = a << b[4:0];
            4'd8: e.res = a >> b[4:0];
            default: begin
                e.res = a - b;
                e.c   = (a < b);
                s     = sa - sbv;
                e.v   = (s > MAXS) || (s < MINS);
            end
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom % 6)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom % 64);
            default: return 32'($urandom);
        endcase
    endfunction

    // Scoreboard: pop/compare on handoff, push on acceptance
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (scb.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL sb_unexpected: got result %h with no request outstanding, required none", result);
                end else begin
                    exp_t e;
                    e = scb.pop_front();
                    tests_run++;
                    if ({result, zero, negative, carry, overflow} !== {e.res, e.z, e.n, e.c, e.v}) begin
                        fails++;
                        $display("FAIL sb_result: got %h z%b n%b c%b v%b, required %h z%b n%b c%b v%b",
                                 result, zero, negative, carry, overflow, e.res, e.z, e.n, e.c, e.v);
                    end
                end
            end
            if (in_valid && in_ready) begin
                scb.push_back(model(control, oper1, oper2));
            end
        end
    end

    // Present one request (called just after a rising edge) and hold it until accepted
    task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int waitc;
        waitc    = 0;
        in_valid = 1'b1;
        control  = op;
        oper1    = a;
        oper2    = b;
        @(negedge clk);
        while (!in_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            tests_run++;
            fails++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waitc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, result, zero, negative, carry, overflow, busy} !== 38'd0) begin
            fails++;
            $display("FAIL reset_state: got ov=%b res=%h z%b n%b c%b v%b busy=%b, required all 0",
                     out_valid, result, zero, negative, carry, overflow, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_add();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || {result, zero, negative, carry, overflow} !== {32'h8000_0000, 4'b0101}) begin
            fails++;
            $display("FAIL add_ovf: got ov=%b %h z%b n%b c%b v%b, required ov=1 80000000 z0 n1 c0 v1",
                     out_valid, result, zero, negative, carry, overflow);
        end
    endtask

    task automatic test_sub();
        @(posedge clk);
        #1;
        drive_op(4'd1, 32'd5, 32'd5);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || {result, zero, carry} !== {32'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL sub_zero: got ov=%b %h z%b c%b, required ov=1 00000000 z1 c0",
                     out_valid, result, zero, carry);
        end
        @(posedge clk);
        #1;
        drive_op(4'd1, 32'd3, 32'd5);
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || {result, zero, negative, carry, overflow} !== {32'hFFFF_FFFE, 4'b0110}) begin
            fails++;
            $display("FAIL sub_borrow: got %h z%b n%b c%b v%b, required fffffffe z0 n1 c1 v0",
                     result, zero, negative, carry, overflow);
        end
    endtask

    task automatic test_mul();
        int busy_cycles;
        int bad_ready;
        bit got;
        busy_cycles = 0;
        bad_ready   = 0;
        got         = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_op(4'd2, 32'h0001_0000, 32'h0001_0000);
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (in_ready) bad_ready++;
            end
        end
        tests_run++;
        if (!got || {result, zero, negative, carry, overflow} !== {32'h0, 4'b1001}) begin
            fails++;
            $display("FAIL mul_result: got valid=%b %h z%b n%b c%b v%b, required 1 00000000 z1 n0 c0 v1",
                     got, result, zero, negative, carry, overflow);
        end
        tests_run++;
        if (busy_cycles != 32 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mul_latency: got busy for %0d cycles (busy now %b), required 32 (0)", busy_cycles, busy);
        end
        tests_run++;
        if (bad_ready != 0) begin
            fails++;
            $display("FAIL mul_in_ready: got in_ready high on %0d busy cycles, required 0", bad_ready);
        end
    endtask

    task automatic test_backpressure();
        int unstable;
        unstable = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_op(4'd3, 32'h0000_F0F0, 32'h0000_0FF0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        control   = 4'd4;
        oper1     = 32'h0000_F0F0;
        oper2     = 32'h0000_0FF0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || result !== 32'h0000_00F0 || in_ready !== 1'b0) unstable++;
        end
        tests_run++;
        if (unstable != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d stall cycles with wrong hold (last ov=%b res=%h rdy=%b), required 0 (1 000000f0 0)",
                     unstable, out_valid, result, in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_handoff_ready: got in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 32'h0000_FFF0) begin
            fails++;
            $display("FAIL bp_no_bubble: got ov=%b res=%h, required 1 0000fff0", out_valid, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [8];
        int         misses;
        ops    = '{4'd0, 4'd1, 4'd3, 4'd6, 4'd7, 4'd8, 4'd12, 4'd15};
        misses = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            control  = ops[i];
            oper1    = rand_operand();
            oper2    = rand_operand();
            @(negedge clk);
            if (in_ready !== 1'b1) misses++;
            if (i > 0 && out_valid !== 1'b1) misses++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (misses != 0) begin
            fails++;
            $display("FAIL b2b_throughput: got %0d bubble/stall cycles, required 0", misses);
        end
    endtask

    task automatic test_random(input int n_ops);
        int waitc;
        rand_done = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < n_ops; i++) begin
                    logic [3:0] op;
                    int         idle;
                    op = 4'($urandom_range(0, 15));
                    if (op == 4'd2 && ($urandom % 2) == 0) op = 4'd0;
                    idle = $urandom_range(0, 2);
                    if (idle > 0) begin
                        repeat (idle) @(posedge clk);
                        #1;
                    end
                    drive_op(op, rand_operand(), rand_operand());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = (($urandom % 4) != 0);
                end
            end
        join
        out_ready = 1'b1;
        waitc     = 0;
        while (scb.size() != 0 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        tests_run++;
        if (scb.size() != 0) begin
            fails++;
            $display("FAIL rand_drain: got %0d results outstanding, required 0", scb.size());
        end
    endtask

    task automatic test_reset_midstream();
        int spurious;
        spurious = 0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive_op(4'd2, 32'h0000_1234, 32'h0000_5678);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({out_valid, result, zero, negative, carry, overflow, busy} !== 38'd0) begin
            fails++;
            $display("FAIL reset_mid: got ov=%b res=%h z%b n%b c%b v%b busy=%b, required all 0",
                     out_valid, result, zero, negative, carry, overflow, busy);
        end
        scb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) spurious++;
        end
        tests_run++;
        if (spurious != 0) begin
            fails++;
            $display("FAIL reset_discard: got %0d cycles with output/busy after reset, required 0", spurious);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_random(3000);
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_seq
`default_nettype wire
